// File: rtl/pool_pkg.sv
// Shared definitions for the max-pool layer sequencer.
//   pool_state_e      : sequencer FSM states
//   MIN_ROW_GAP       : smallest idle gap between rows, so pool_vld always falls between rows
//   STRIDE2 / STRIDE1 : encodings of cfg_stride / pool_stride
//   expected_outputs(): number of pool outputs a layer produces for a given stride and side N
package pool_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPad,
    StRow,
    StGap,
    StDrain,
    StDone
  } pool_state_e;

  localparam int unsigned MIN_ROW_GAP = 2;

  localparam logic STRIDE2 = 1'b0;
  localparam logic STRIDE1 = 1'b1;

  localparam int unsigned OUT_CNT_W = 11;
  localparam logic [OUT_CNT_W-1:0] OUT_CNT_MAX = '1;

  // Stride 1 yields N*N outputs, stride 2 yields (N/2)*(N/2). N <= 32, so the result fits 11 bits.
  function automatic logic [OUT_CNT_W-1:0] expected_outputs(input logic       stride,
                                                            input logic [5:0] fm_size);
    logic [OUT_CNT_W-1:0] side;
    side = (stride == STRIDE1) ? {5'd0, fm_size} : {6'd0, fm_size[5:1]};
    return side * side;
  endfunction

endpackage

// File: rtl/vld_delay_line.sv
// Fixed-latency delay line that aligns the pool input-valid with feature-RAM read data.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   vld_i         : read enable issued this cycle
//   vld_o         : vld_i delayed by RD_LAT cycles
// The line shifts every cycle regardless of the sequencer state.
module vld_delay_line #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic vld_i,
  output logic vld_o
);

  logic [RD_LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d[0] = vld_i;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/pool_layer_ctrl.sv
// Layer-level sequencer for the 8-channel max-pool datapath.
// A start pulse latches the layer config, pulses padding_start, then scans the feature buffer
// row by row (N reads per row, idle gap between rows), feeds pool_vld through the RAM-latency
// delay line, counts returned pool outputs and finishes with layer_done (or layer_err on a
// drain timeout).
//   sclk, s_rst_n                : clock, asynchronous active-low reset
//   layer_start                  : one-cycle start pulse, accepted only when idle
//   cfg_stride/fm_size/base/gap  : layer config, sampled on an accepted start
//   row_stall                    : downstream not ready, honoured at row boundaries
//   pool_out_vld                 : output valid returned by the pool
//   busy, layer_done, layer_err  : layer status
//   padding_start, pool_stride   : pool control
//   rd_en, rd_addr               : feature-RAM read port
//   pool_vld                     : pool input valid (rd_en delayed by RD_LAT)
//   out_cnt                      : saturating count of pool outputs this layer
module pool_layer_ctrl
  import pool_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned DRAIN_TMO = 64
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              layer_start,
  input  logic              cfg_stride,
  input  logic [5:0]        cfg_fm_size,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [3:0]        cfg_row_gap,
  input  logic              row_stall,
  input  logic              pool_out_vld,
  output logic              busy,
  output logic              layer_done,
  output logic              layer_err,
  output logic              padding_start,
  output logic              pool_stride,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pool_vld,
  output logic [10:0]       out_cnt
);

  localparam int unsigned TMO_W = $clog2(DRAIN_TMO + 1);

  pool_state_e          state_q, state_d;
  logic                 stride_q, stride_d;
  logic [5:0]           n_q, n_d;
  logic [3:0]           gap_len_q, gap_len_d;
  logic [OUT_CNT_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [5:0]           col_q, col_d;
  logic [5:0]           row_q, row_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 err_q, err_d;

  logic busy_int;

  assign busy_int = state_q inside {StPad, StRow, StGap, StDrain};

  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    n_d       = n_q;
    gap_len_d = gap_len_q;
    exp_d     = exp_q;
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_cnt_d = gap_cnt_q;
    tmo_d     = tmo_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;

    if (busy_int && pool_out_vld && (out_cnt_q != OUT_CNT_MAX)) begin
      out_cnt_d = out_cnt_q + 11'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (layer_start) begin
          stride_d  = cfg_stride;
          n_d       = cfg_fm_size;
          gap_len_d = (cfg_row_gap < 4'(MIN_ROW_GAP)) ? 4'(MIN_ROW_GAP) : cfg_row_gap;
          exp_d     = expected_outputs(cfg_stride, cfg_fm_size);
          addr_d    = cfg_base;
          col_d     = '0;
          row_d     = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = StPad;
        end
      end
      StPad: begin
        state_d = StRow;
      end
      StRow: begin
        // Rows are contiguous in the buffer, so one running address covers base + row*N + col.
        addr_d = addr_q + 1'b1;
        if (col_q == n_q - 6'd1) begin
          col_d     = '0;
          gap_cnt_d = '0;
          // Counts cycles since the last read; the last read itself is cycle 0.
          tmo_d     = TMO_W'(1);
          if (row_q == n_q - 6'd1) begin
            state_d = StDrain;
          end else begin
            row_d   = row_q + 6'd1;
            state_d = StGap;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q >= gap_len_q - 4'd1) begin
          if (!row_stall) begin
            state_d = StRow;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StDrain: begin
        // A count match wins over a simultaneous timeout.
        if (out_cnt_q == exp_q) begin
          state_d = StDone;
        end else if (tmo_q >= TMO_W'(DRAIN_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= StIdle;
      stride_q  <= STRIDE2;
      n_q       <= '0;
      gap_len_q <= '0;
      exp_q     <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      gap_cnt_q <= '0;
      tmo_q     <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      n_q       <= n_d;
      gap_len_q <= gap_len_d;
      exp_q     <= exp_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_q     <= tmo_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  vld_delay_line #(
    .RD_LAT(RD_LAT)
  ) u_vld_delay_line (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .vld_i  (rd_en),
    .vld_o  (pool_vld)
  );

  assign busy          = busy_int;
  assign layer_done    = (state_q == StDone);
  assign layer_err     = err_q;
  assign padding_start = (state_q == StPad);
  assign pool_stride   = stride_q;
  assign rd_en         = (state_q == StRow);
  assign rd_addr       = addr_q;
  assign out_cnt       = out_cnt_q;

endmodule

// File: tb/tb_pool_layer_ctrl.sv
module tb_pool_layer_ctrl;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned DRAIN_TMO = 64;

  logic              sclk = 1'b0;
  logic              s_rst_n;
  logic              layer_start;
  logic              cfg_stride;
  logic [5:0]        cfg_fm_size;
  logic [ADDR_W-1:0] cfg_base;
  logic [3:0]        cfg_row_gap;
  logic              row_stall;
  logic              pool_out_vld;
  logic              busy, layer_done, layer_err, padding_start, pool_stride, rd_en, pool_vld;
  logic [ADDR_W-1:0] rd_addr;
  logic [10:0]       out_cnt;

  pool_layer_ctrl #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .DRAIN_TMO(DRAIN_TMO)
  ) dut (
    .sclk         (sclk),
    .s_rst_n      (s_rst_n),
    .layer_start  (layer_start),
    .cfg_stride   (cfg_stride),
    .cfg_fm_size  (cfg_fm_size),
    .cfg_base     (cfg_base),
    .cfg_row_gap  (cfg_row_gap),
    .row_stall    (row_stall),
    .pool_out_vld (pool_out_vld),
    .busy         (busy),
    .layer_done   (layer_done),
    .layer_err    (layer_err),
    .padding_start(padding_start),
    .pool_stride  (pool_stride),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .pool_vld     (pool_vld),
    .out_cnt      (out_cnt)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Monitor state
  int                bursts[$];
  int                gaps[$];
  logic [ADDR_W-1:0] addrs[$];
  int                run, gap_run, pad_cnt, done_cnt, lag_err, stride_bad, last_rd_cyc, done_cyc;
  bit                prev_rd, seen_burst, exp_stride;
  logic [RD_LAT-1:0] hist;

  // Pool model state
  int pool_div, pool_quota, pool_in, pool_emit;
  bit pool_force;

  initial begin
    hist = '0;
    forever begin
      @(negedge sclk);
      if (!s_rst_n) begin
        hist    = '0;
        prev_rd = 1'b0;
      end else begin
        if (pool_vld !== hist[RD_LAT-1]) lag_err++;
        hist = {hist[RD_LAT-2:0], rd_en};
        if (rd_en) begin
          addrs.push_back(rd_addr);
          last_rd_cyc = cyc;
          if (!prev_rd) begin
            if (seen_burst) gaps.push_back(gap_run);
            run = 1;
          end else begin
            run++;
          end
        end else if (prev_rd) begin
          bursts.push_back(run);
          seen_burst = 1'b1;
          gap_run    = 1;
        end else begin
          gap_run++;
        end
        prev_rd = rd_en;
        if (padding_start) pad_cnt++;
        if (layer_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy && (pool_stride !== exp_stride)) stride_bad++;
      end
    end
  end

  // Pool model: one output per pool_div inputs, at most pool_quota outputs.
  initial begin
    pool_out_vld = 1'b0;
    forever begin
      @(negedge sclk);
      if (pool_force) begin
        pool_out_vld = 1'b1;
      end else if (pool_vld === 1'b1) begin
        pool_in++;
        if ((pool_in % pool_div == 0) && (pool_emit < pool_quota)) begin
          pool_out_vld = 1'b1;
          pool_emit++;
        end else begin
          pool_out_vld = 1'b0;
        end
      end else begin
        pool_out_vld = 1'b0;
      end
    end
  end

  task automatic mon_clear();
    bursts.delete();
    gaps.delete();
    addrs.delete();
    run = 0; gap_run = 0; pad_cnt = 0; done_cnt = 0; lag_err = 0; stride_bad = 0;
    last_rd_cyc = 0; done_cyc = 0; prev_rd = 1'b0; seen_burst = 1'b0;
  endtask

  task automatic pool_setup(input int div, input int quota);
    pool_div = div; pool_quota = quota; pool_in = 0; pool_emit = 0;
  endtask

  task automatic start_layer(input logic stride, input logic [5:0] n,
                             input logic [ADDR_W-1:0] base, input logic [3:0] gap);
    @(negedge sclk);
    cfg_stride = stride; cfg_fm_size = n; cfg_base = base; cfg_row_gap = gap;
    exp_stride = stride;
    layer_start = 1'b1;
    @(negedge sclk);
    layer_start = 1'b0;
    // Scramble config to prove it was latched.
    cfg_stride = ~stride; cfg_fm_size = 6'd10; cfg_base = 12'hABC; cfg_row_gap = 4'd7;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sclk);
      #1;
      if (layer_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int addr_errs(input logic [ADDR_W-1:0] base, input int n);
    int e;
    e = (addrs.size() != n) ? 1 : 0;
    for (int i = 0; i < addrs.size(); i++) begin
      if (addrs[i] !== ADDR_W'(base + ADDR_W'(i))) e++;
    end
    return e;
  endfunction

  function automatic int q_errs(input int q[$], input int len, input int val);
    int e;
    e = (q.size() != len) ? 1 : 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] != val) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [29:0] ov;
    s_rst_n = 1'b1;
    #2 s_rst_n = 1'b0;
    #1;
    ov = {busy, layer_done, layer_err, padding_start, pool_stride, rd_en, rd_addr, pool_vld,
          out_cnt};
    total++; if (ov !== '0) $display("FAIL reset_outputs: got %h want 0", ov); else passed++;
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_stride2();
    bit ok;
    mon_clear(); pool_setup(4, 4);
    start_layer(1'b0, 6'd4, 12'h100, 4'd2);
    #1;
    total++; if ({busy, padding_start} !== 2'b11)
      $display("FAIL s2_pad_busy: got %b want 11", {busy, padding_start}); else passed++;
    wait_done(300, ok);
    total++; if (!ok) $display("FAIL s2_done_seen: got 0 want 1"); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL s2_busy_at_done: got %b want 0", busy);
    else passed++;
    repeat (3) @(negedge sclk);
    #1;
    total++; if (addr_errs(12'h100, 16) != 0)
      $display("FAIL s2_addrs: got %0d errors want 0", addr_errs(12'h100, 16)); else passed++;
    total++; if (q_errs(bursts, 4, 4) != 0)
      $display("FAIL s2_bursts: got %0d errors want 0", q_errs(bursts, 4, 4)); else passed++;
    total++; if (q_errs(gaps, 3, 2) != 0)
      $display("FAIL s2_gaps: got %0d errors want 0", q_errs(gaps, 3, 2)); else passed++;
    total++; if (pad_cnt != 1) $display("FAIL s2_pad_cnt: got %0d want 1", pad_cnt);
    else passed++;
    total++; if (done_cnt != 1) $display("FAIL s2_done_cnt: got %0d want 1", done_cnt);
    else passed++;
    total++; if (out_cnt !== 11'd4) $display("FAIL s2_out_cnt: got %0d want 4", out_cnt);
    else passed++;
    total++; if (layer_err !== 1'b0) $display("FAIL s2_err: got %b want 0", layer_err);
    else passed++;
    total++; if (stride_bad != 0) $display("FAIL s2_stride: got %0d bad want 0", stride_bad);
    else passed++;
    // Pool outputs while idle must not count.
    pool_force = 1'b1;
    repeat (3) @(negedge sclk);
    pool_force = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
    total++; if (out_cnt !== 11'd4) $display("FAIL idle_vld_ignored: got %0d want 4", out_cnt);
    else passed++;
  endtask

  task automatic test_stride1();
    bit ok;
    mon_clear(); pool_setup(1, 9);
    start_layer(1'b1, 6'd3, 12'h040, 4'd0);
    wait_done(300, ok);
    total++; if (!ok) $display("FAIL s1_done_seen: got 0 want 1"); else passed++;
    repeat (3) @(negedge sclk);
    #1;
    total++; if (addr_errs(12'h040, 9) != 0)
      $display("FAIL s1_addrs: got %0d errors want 0", addr_errs(12'h040, 9)); else passed++;
    total++; if (q_errs(bursts, 3, 3) != 0)
      $display("FAIL s1_bursts: got %0d errors want 0", q_errs(bursts, 3, 3)); else passed++;
    total++; if (q_errs(gaps, 2, 2) != 0)
      $display("FAIL s1_gap_clamp: got %0d errors want 0", q_errs(gaps, 2, 2)); else passed++;
    total++; if (lag_err != 0) $display("FAIL s1_vld_lag: got %0d errors want 0", lag_err);
    else passed++;
    total++; if (out_cnt !== 11'd9) $display("FAIL s1_out_cnt: got %0d want 9", out_cnt);
    else passed++;
    total++; if ({layer_err, pool_stride} !== 2'b01)
      $display("FAIL s1_err_stride: got %b want 01", {layer_err, pool_stride}); else passed++;
  endtask

  task automatic test_stall();
    bit ok;
    mon_clear(); pool_setup(4, 4);
    start_layer(1'b0, 6'd4, 12'h100, 4'd2);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sclk);
      #1;
      if (bursts.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL stall_reach_gap2: got 0 want 1"); else passed++;
    row_stall = 1'b1;
    repeat (10) @(negedge sclk);
    row_stall = 1'b0;
    wait_done(300, ok);
    total++; if (!ok) $display("FAIL stall_done_seen: got 0 want 1"); else passed++;
    repeat (2) @(negedge sclk);
    #1;
    total++; if (addr_errs(12'h100, 16) != 0)
      $display("FAIL stall_addrs: got %0d errors want 0", addr_errs(12'h100, 16)); else passed++;
    total++; if (gaps.size() != 3) $display("FAIL stall_gap_count: got %0d want 3", gaps.size());
    else passed++;
    total++; if (gaps[1] != 11) $display("FAIL stall_gap_len: got %0d want 11", gaps[1]);
    else passed++;
    total++; if (out_cnt !== 11'd4 || layer_err !== 1'b0)
      $display("FAIL stall_result: got cnt %0d err %b want cnt 4 err 0", out_cnt, layer_err);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    mon_clear(); pool_setup(4, 3);
    start_layer(1'b0, 6'd4, 12'h100, 4'd2);
    wait_done(300, ok);
    total++; if (!ok) $display("FAIL tmo_done_seen: got 0 want 1"); else passed++;
    repeat (2) @(negedge sclk);
    #1;
    total++; if (done_cyc - last_rd_cyc != DRAIN_TMO)
      $display("FAIL tmo_latency: got %0d want %0d", done_cyc - last_rd_cyc, DRAIN_TMO);
    else passed++;
    total++; if (out_cnt !== 11'd3) $display("FAIL tmo_out_cnt: got %0d want 3", out_cnt);
    else passed++;
    repeat (5) @(negedge sclk);
    #1;
    total++; if (layer_err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", layer_err);
    else passed++;
    mon_clear(); pool_setup(4, 4);
    start_layer(1'b0, 6'd4, 12'h200, 4'd3);
    #1;
    total++; if (layer_err !== 1'b0) $display("FAIL tmo_err_cleared: got %b want 0", layer_err);
    else passed++;
    wait_done(300, ok);
    repeat (2) @(negedge sclk);
    #1;
    total++; if (!ok || layer_err !== 1'b0 || out_cnt !== 11'd4)
      $display("FAIL tmo_next_layer: got ok %b err %b cnt %0d want 1 0 4", ok, layer_err,
               out_cnt);
    else passed++;
    total++; if (q_errs(gaps, 3, 3) != 0 || addr_errs(12'h200, 16) != 0)
      $display("FAIL tmo_next_scan: got %0d gap errors %0d addr errors want 0 0",
               q_errs(gaps, 3, 3), addr_errs(12'h200, 16));
    else passed++;
  endtask

  task automatic test_ignore_start();
    bit ok;
    mon_clear(); pool_setup(4, 4);
    start_layer(1'b0, 6'd4, 12'h100, 4'd2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk);
      #1;
      if (rd_en && addrs.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL ign_reach_row: got 0 want 1"); else passed++;
    cfg_stride = 1'b1; cfg_fm_size = 6'd6; cfg_base = 12'h300; cfg_row_gap = 4'd0;
    layer_start = 1'b1;
    @(negedge sclk);
    layer_start = 1'b0;
    wait_done(300, ok);
    repeat (3) @(negedge sclk);
    #1;
    total++; if (addr_errs(12'h100, 16) != 0)
      $display("FAIL ign_addrs: got %0d errors want 0", addr_errs(12'h100, 16)); else passed++;
    total++; if (stride_bad != 0 || pool_stride !== 1'b0)
      $display("FAIL ign_stride: got %0d bad, stride %b want 0 0", stride_bad, pool_stride);
    else passed++;
    total++; if (pad_cnt != 1 || done_cnt != 1 || out_cnt !== 11'd4)
      $display("FAIL ign_layer: got pad %0d done %0d cnt %0d want 1 1 4", pad_cnt, done_cnt,
               out_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    logic [29:0] ov;
    mon_clear(); pool_setup(1, 9);
    start_layer(1'b1, 6'd3, 12'h040, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk);
      #1;
      if (rd_en && rd_addr == 12'h044) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL rst_reach_row: got 0 want 1"); else passed++;
    #1 s_rst_n = 1'b0;
    #1;
    ov = {busy, layer_done, layer_err, padding_start, pool_stride, rd_en, rd_addr, pool_vld,
          out_cnt};
    total++; if (ov !== '0) $display("FAIL rst_mid_outputs: got %h want 0", ov); else passed++;
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    #1;
    total++; if (done_cnt != 0 || busy !== 1'b0)
      $display("FAIL rst_no_done: got done %0d busy %b want 0 0", done_cnt, busy); else passed++;
    mon_clear(); pool_setup(1, 9);
    start_layer(1'b1, 6'd3, 12'h040, 4'd0);
    wait_done(300, ok);
    repeat (2) @(negedge sclk);
    #1;
    total++; if (!ok || addr_errs(12'h040, 9) != 0 || out_cnt !== 11'd9 || layer_err !== 1'b0)
      $display("FAIL rst_fresh_layer: got ok %b addr errs %0d cnt %0d err %b want 1 0 9 0", ok,
               addr_errs(12'h040, 9), out_cnt, layer_err);
    else passed++;
  endtask

  task automatic test_saturate();
    bit ok;
    mon_clear(); pool_setup(4, 0);
    start_layer(1'b0, 6'd4, 12'h100, 4'd2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk);
      #1;
      if (bursts.size() == 1) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL sat_reach_gap: got 0 want 1"); else passed++;
    row_stall  = 1'b1;
    pool_force = 1'b1;
    repeat (2100) @(negedge sclk);
    pool_force = 1'b0;
    @(negedge sclk);
    #1;
    total++; if (out_cnt !== 11'd2047) $display("FAIL sat_out_cnt: got %0d want 2047", out_cnt);
    else passed++;
    row_stall = 1'b0;
    wait_done(300, ok);
    #1;
    total++; if (!ok || layer_err !== 1'b1 || out_cnt !== 11'd2047)
      $display("FAIL sat_timeout: got ok %b err %b cnt %0d want 1 1 2047", ok, layer_err,
               out_cnt);
    else passed++;
  endtask

  initial begin
    s_rst_n = 1'b1; layer_start = 1'b0; cfg_stride = 1'b0; cfg_fm_size = '0; cfg_base = '0;
    cfg_row_gap = '0; row_stall = 1'b0; pool_force = 1'b0; exp_stride = 1'b0;
    mon_clear(); pool_setup(1, 0);
    test_reset();
    test_stride2();
    test_stride1();
    test_stall();
    test_timeout();
    test_ignore_start();
    test_reset_mid_row();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pool_layer_ctrl.md
Name: pool_layer_ctrl

Overview:
Layer-level sequencer for the 8-channel max-pool datapath. On a start pulse it latches the layer config and emits the pool's mode and padding pulse. It then scans the feature-buffer RAM row by row and drives the pool's input-valid bursts, with idle gaps between rows. It counts the pool's output valids and signals layer completion, or an error on timeout.

Parameters:
ADDR_W, 12, feature-buffer read address width
RD_LAT, 1, feature-RAM read latency in cycles, 1..4
DRAIN_TMO, 64, max cycles to wait for remaining pool outputs after the last read

Ports:
sclk  in  1  clock
s_rst_n  in  1  reset; asynchronous, active-low
layer_start  in  1  one-cycle start pulse
cfg_stride  in  1  0: stride 2, 1: stride 1; sampled at layer_start
cfg_fm_size  in  6  feature-map side N (square), 2..32; must be even for stride 2
cfg_base  in  ADDR_W  RAM address of pixel (0,0)
cfg_row_gap  in  4  idle cycles between rows, effective minimum 2
row_stall  in  1  downstream not ready; honoured only at row boundaries
pool_out_vld  in  1  output-valid returned from the pool
busy  out  1  high from the cycle after an accepted start until done
layer_done  out  1  one-cycle completion pulse
layer_err  out  1  sticky drain-timeout flag; cleared by the next accepted start
padding_start  out  1  one-cycle pulse to the pool before the first row
pool_stride  out  1  latched cfg_stride, stable for the whole layer
rd_en  out  1  feature-RAM read enable
rd_addr  out  ADDR_W  feature-RAM read address
pool_vld  out  1  pool input-valid, rd_en delayed by RD_LAT
out_cnt  out  11  pool outputs counted in the current layer

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; delay line and counters cleared.
- Reset mid-operation returns to IDLE immediately. No done pulse is issued.
- FSM states: IDLE, PAD, ROW, GAP, DRAIN, DONE.
- IDLE:
  - layer_start latches cfg_* into shadow registers.
  - Clears out_cnt and layer_err.
  - Moves to PAD.
  - layer_start outside IDLE is ignored.
- PAD: padding_start=1 for exactly one cycle, then ROW. pool_stride takes the latched value on entry to PAD.
- ROW:
  - rd_en=1 for exactly N consecutive cycles.
  - rd_addr starts at cfg_base + row*N and increments by 1 each cycle. Use an incremental address register, no multiplier.
  - After the Nth read: go to DRAIN if this was row N-1, otherwise GAP.
- GAP:
  - rd_en=0 for max(cfg_row_gap, 2) cycles; this guarantees a falling edge of pool_vld between rows.
  - At the end of the gap: if row_stall=1, remain in GAP until it drops; otherwise ROW with row+1.
- pool_vld: shift register of depth RD_LAT fed by rd_en. The delay line keeps shifting in every state.
- out_cnt: increments on every pool_out_vld while busy; it saturates at 2047 and does not wrap.
- Expected output count E:
  - stride 1: E = N*N
  - stride 2: E = (N/2)*(N/2)
- DRAIN:
  - Waits until out_cnt == E, then DONE.
  - If DRAIN_TMO cycles elapse first: set layer_err=1, then DONE.
  - If out_cnt == E is reached in the same cycle as the timeout, it is a success with no error.
- DONE: layer_done=1 for one cycle, busy drops in the same cycle, then IDLE.
- pool_out_vld arriving outside busy is ignored.

Decomposition:
- Shared package pool_pkg:
  - FSM state encoding constants
  - MIN_ROW_GAP = 2
  - stride mode constants STRIDE2 = 0, STRIDE1 = 1
- One natural sub-module, vld_delay_line: parameterised RD_LAT shift register carrying rd_en to pool_vld.
- Everything else stays inline.

Test Plan:
- Stride-2 layer: N=4, cfg_base=0x100, gap=2, pool returns 4 valids → rd_addr 0x100..0x10F in 4 bursts of 4, 2-cycle gaps, one padding_start pulse, out_cnt=4, single layer_done, layer_err=0.
- Stride-1 layer: N=3, gap=0 (clamped to 2), RD_LAT=2 → pool_vld lags rd_en by exactly 2 cycles, gap measured as 2, done after 9 outputs.
- Stall: row_stall held high for 10 cycles during the 2nd GAP → rd_en stays low until row_stall falls, no read lost, addresses contiguous.
- Timeout: N=4 stride 2, pool returns only 3 valids → layer_err=1, layer_done exactly DRAIN_TMO cycles after the last read; next layer_start clears layer_err.
- layer_start pulsed while busy with different cfg values → ignored, pool_stride and addresses unchanged.
- Asynchronous reset asserted mid-ROW → all outputs 0 immediately, no layer_done; a fresh start afterwards runs a complete correct layer.
